// File: rtl/alu_stream_pkg.sv
// Shared opcode map and FSM state type for the streaming ALU.
package alu_stream_pkg;

  localparam logic [3:0] OP_AND  = 4'd0;
  localparam logic [3:0] OP_OR   = 4'd1;
  localparam logic [3:0] OP_ADD  = 4'd2;
  localparam logic [3:0] OP_SLTU = 4'd3;
  localparam logic [3:0] OP_XOR  = 4'd4;
  localparam logic [3:0] OP_SUB  = 4'd6;
  localparam logic [3:0] OP_SLT  = 4'd7;
  localparam logic [3:0] OP_SLL  = 4'd8;
  localparam logic [3:0] OP_SRL  = 4'd9;
  localparam logic [3:0] OP_SRA  = 4'd10;
  localparam logic [3:0] OP_NOR  = 4'd12;
  localparam logic [3:0] OP_MUL  = 4'd13;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_HOLD = 2'd1,
    ST_MUL  = 2'd2
  } state_t;

endpackage

// File: rtl/alu_mul_iter.sv
// Iterative shift-add unsigned multiplier: one partial product per clock,
// WIDTH steps per operation. `done` and `product` describe the final step.
module alu_mul_iter #(
  parameter int WIDTH = 32,
  parameter int SHW   = $clog2(WIDTH)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic [WIDTH-1:0]     a,
  input  logic [WIDTH-1:0]     b,
  output logic                 done,
  output logic [2*WIDTH-1:0]   product
);

  logic               busy;
  logic [SHW-1:0]     count;
  logic [WIDTH-1:0]   mcand;
  logic [2*WIDTH-1:0] acc;
  logic [WIDTH:0]     sum;

  // Multiplier sits in the low half of acc and is consumed LSB-first.
  always_comb begin
    sum     = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, mcand} : '0);
    product = {sum, acc[WIDTH-1:1]};
  end

  assign done = busy && (count == SHW'(WIDTH - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy  <= 1'b0;
      count <= '0;
      mcand <= '0;
      acc   <= '0;
    end else if (start) begin
      busy  <= 1'b1;
      count <= '0;
      mcand <= a;
      acc   <= {{WIDTH{1'b0}}, b};
    end else if (busy) begin
      acc   <= product;
      count <= count + SHW'(1);
      if (done) busy <= 1'b0;
    end
  end

endmodule

// File: rtl/alu_stream.sv
// Handshaked ALU with registered result. Define ALU_STREAM_MUL_EN to build
// in the iterative multiplier (opcode 13) and the ResultHi datapath.
module alu_stream #(
  parameter int WIDTH = 32,
  parameter int SHW   = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             InValid,
  output logic             InReady,
  input  logic [WIDTH-1:0] DataIn1,
  input  logic [WIDTH-1:0] DataIn2,
  input  logic [3:0]       Operation,
  output logic             OutValid,
  input  logic             OutReady,
  output logic [WIDTH-1:0] Result,
  output logic [WIDTH-1:0] ResultHi,
  output logic             Zero,
  output logic             Overflow
);
  import alu_stream_pkg::*;

  state_t           state;
  logic             accept;
  logic             consume;
  logic             is_mul;
  logic [WIDTH-1:0] res;
  logic             ovf;
  logic [WIDTH-1:0] sum;
  logic [WIDTH-1:0] diff;
  logic [SHW-1:0]   shamt;
  logic [WIDTH-1:0] result_q;
  logic             zero_q;
  logic             ovf_q;

  assign InReady  = (state == ST_IDLE) || ((state == ST_HOLD) && OutReady);
  assign OutValid = (state == ST_HOLD);
  assign accept   = InValid && InReady;
  assign consume  = OutValid && OutReady;
  assign shamt    = DataIn2[SHW-1:0];

  always_comb begin
    res  = '0;
    ovf  = 1'b0;
    sum  = DataIn1 + DataIn2;
    diff = DataIn1 - DataIn2;
    case (Operation)
      OP_AND:  res = DataIn1 & DataIn2;
      OP_OR:   res = DataIn1 | DataIn2;
      OP_ADD: begin
        res = sum;
        ovf = (DataIn1[WIDTH-1] == DataIn2[WIDTH-1]) && (sum[WIDTH-1] != DataIn1[WIDTH-1]);
      end
      OP_SLTU: res = {{(WIDTH-1){1'b0}}, DataIn1 < DataIn2};
      OP_XOR:  res = DataIn1 ^ DataIn2;
      OP_SUB: begin
        res = diff;
        ovf = (DataIn1[WIDTH-1] != DataIn2[WIDTH-1]) && (diff[WIDTH-1] != DataIn1[WIDTH-1]);
      end
      OP_SLT:  res = {{(WIDTH-1){1'b0}}, $signed(DataIn1) < $signed(DataIn2)};
      OP_SLL:  res = DataIn1 << shamt;
      OP_SRL:  res = DataIn1 >> shamt;
      OP_SRA:  res = $signed(DataIn1) >>> shamt;
      OP_NOR:  res = ~(DataIn1 | DataIn2);
      default: res = '0;
    endcase
  end

`ifdef ALU_STREAM_MUL_EN
  logic                 mul_done;
  logic [2*WIDTH-1:0]   product;
  logic [WIDTH-1:0]     resulthi_q;

  assign is_mul = (Operation == OP_MUL);

  alu_mul_iter #(.WIDTH(WIDTH)) u_mul (
    .clk     (clk),
    .rst_n   (rst_n),
    .start   (accept && is_mul),
    .a       (DataIn1),
    .b       (DataIn2),
    .done    (mul_done),
    .product (product)
  );

  assign ResultHi = resulthi_q;
`else
  assign is_mul   = 1'b0;
  assign ResultHi = '0;
`endif

  // IDLE and HOLD share one branch: accept is only possible in HOLD when the
  // current result is consumed in the same cycle, and consume is never true in IDLE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= ST_IDLE;
      result_q <= '0;
      zero_q   <= 1'b0;
      ovf_q    <= 1'b0;
`ifdef ALU_STREAM_MUL_EN
      resulthi_q <= '0;
`endif
    end else begin
      case (state)
        ST_IDLE, ST_HOLD: begin
          if (accept) begin
            if (is_mul) begin
              state <= ST_MUL;
            end else begin
              state    <= ST_HOLD;
              result_q <= res;
              zero_q   <= (res == '0);
              ovf_q    <= ovf;
`ifdef ALU_STREAM_MUL_EN
              resulthi_q <= '0;
`endif
            end
          end else if (consume) begin
            state <= ST_IDLE;
          end
        end
`ifdef ALU_STREAM_MUL_EN
        ST_MUL: begin
          if (mul_done) begin
            state      <= ST_HOLD;
            result_q   <= product[WIDTH-1:0];
            resulthi_q <= product[2*WIDTH-1:WIDTH];
            zero_q     <= (product[WIDTH-1:0] == '0);
            ovf_q      <= 1'b0;
          end
        end
`endif
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign Result   = result_q;
  assign Zero     = zero_q;
  assign Overflow = ovf_q;

endmodule

// File: tb/tb_alu_stream.sv
// Scoreboard bench for alu_stream: driver pushes model results on accept,
// negedge monitor pops and compares on every consume.
module tb_alu_stream;
  import alu_stream_pkg::*;

  localparam int WIDTH = 32;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              InValid, InReady, OutValid, OutReady, Zero, Overflow;
  logic [WIDTH-1:0]  DataIn1, DataIn2, Result, ResultHi;
  logic [3:0]        Operation;

  always #5 clk = ~clk;

  alu_stream #(.WIDTH(WIDTH)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .InValid   (InValid),
    .InReady   (InReady),
    .DataIn1   (DataIn1),
    .DataIn2   (DataIn2),
    .Operation (Operation),
    .OutValid  (OutValid),
    .OutReady  (OutReady),
    .Result    (Result),
    .ResultHi  (ResultHi),
    .Zero      (Zero),
    .Overflow  (Overflow)
  );

  typedef struct {
    logic [3:0]  op;
    logic [31:0] r;
    logic [31:0] hi;
    logic        z;
    logic        o;
  } exp_t;

  exp_t q[$];
  int   cons_cyc[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  int   n_cons   = 0;
  int   cyc      = 0;
  bit   rand_ready = 1'b0;

  always @(posedge clk) cyc++;

  // Reference behaviour from the opcode table, using wide signed arithmetic.
  function automatic exp_t model(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    exp_t        e;
    longint      sa, sb, s;
    int unsigned sh;
    logic [63:0] p;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    sh = int'(b & 32'd31);
    s = 0;
    p = '0;
    e.op = op;
    e.r  = '0;
    e.hi = '0;
    e.o  = 1'b0;
    case (op)
      OP_AND:  e.r = a & b;
      OP_OR:   e.r = a | b;
      OP_ADD: begin s = sa + sb; e.r = s[31:0]; e.o = (s != longint'($signed(e.r))); end
      OP_SUB: begin s = sa - sb; e.r = s[31:0]; e.o = (s != longint'($signed(e.r))); end
      OP_SLTU: e.r = {31'b0, a < b};
      OP_SLT:  e.r = {31'b0, sa < sb};
      OP_XOR:  e.r = a ^ b;
      OP_SLL:  e.r = a << sh;
      OP_SRL:  e.r = a >> sh;
      OP_SRA: begin s = sa >>> sh; e.r = s[31:0]; end
      OP_NOR:  e.r = ~(a | b);
`ifdef ALU_STREAM_MUL_EN
      OP_MUL: begin p = {32'b0, a} * {32'b0, b}; e.r = p[31:0]; e.hi = p[63:32]; end
`endif
      default: e.r = '0;
    endcase
    e.z = (e.r == 32'd0);
    return e;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (rst_n && OutValid && OutReady) begin
      n_cons++;
      cons_cyc.push_back(cyc);
      n_checks++;
      if (q.size() == 0) begin
        n_fail++;
        $display("FAIL unexpected_output: got Result=%h with no transaction outstanding", Result);
      end else begin
        e = q.pop_front();
        if ({Result, ResultHi, Zero, Overflow} !== {e.r, e.hi, e.z, e.o}) begin
          n_fail++;
          $display("FAIL result_op%0d: got R=%h H=%h Z=%b O=%b expected R=%h H=%h Z=%b O=%b",
                   e.op, Result, ResultHi, Zero, Overflow, e.r, e.hi, e.z, e.o);
        end
      end
    end
  end

  always @(posedge clk) begin
    #1;
    if (rand_ready) OutReady = ($urandom % 4) != 0;
  end

  task automatic issue(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b, output bit first);
    int tries;
    bit done;
    tries = 0;
    done  = 1'b0;
    first = 1'b0;
    @(posedge clk); #1;
    InValid = 1'b1; Operation = op; DataIn1 = a; DataIn2 = b;
    while (!done) begin
      @(negedge clk);
      if (InReady) begin
        q.push_back(model(op, a, b));
        first = (tries == 0);
        done  = 1'b1;
      end else begin
        tries++;
        if (tries > 200) begin
          chk("accept_timeout", 64'(tries), 64'd0);
          done = 1'b1;
        end else begin
          @(posedge clk); #1;
        end
      end
    end
  endtask

  task automatic idle_cycle();
    @(posedge clk); #1;
    InValid = 1'b0;
  endtask

  function automatic logic [31:0] pick();
    case ($urandom % 6)
      0: return 32'h0000_0000;
      1: return 32'h7FFF_FFFF;
      2: return 32'h8000_0000;
      3: return 32'hFFFF_FFFF;
      default: return $urandom;
    endcase
  endfunction

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bit f1, f2, seen;
    int base, n, diff;
    logic [31:0] snap;

    InValid = 1'b0; Operation = '0; DataIn1 = '0; DataIn2 = '0; OutReady = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("reset_flags", 64'({OutValid, InReady, Zero, Overflow}), 64'(4'b0100));
    chk("reset_result", 64'(Result), 64'd0);
    chk("reset_hi", 64'(ResultHi), 64'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;

    OutReady = 1'b1;
    issue(OP_ADD, 32'h7FFF_FFFF, 32'h0000_0001, f1);
    idle_cycle();
    @(negedge clk);
    chk("add_latency_valid", 64'(OutValid), 64'd1);
    chk("add_result", 64'(Result), 64'h8000_0000);
    chk("add_flags", 64'({Overflow, Zero}), 64'(2'b10));

    issue(OP_SUB, 32'h0000_1234, 32'h0000_1234, f1);
    issue(4'd5, $urandom, $urandom, f1);
    issue(OP_SLT, 32'hFFFF_FFFF, 32'h0000_0001, f1);
    issue(OP_SLTU, 32'hFFFF_FFFF, 32'h0000_0001, f1);
    issue(OP_SRA, 32'h8000_0000, 32'd4, f1);
    issue(4'd13, 32'hFFFF_FFFF, 32'h0000_0002, f1);
    idle_cycle();
    repeat (WIDTH + 4) idle_cycle();

    base = cons_cyc.size();
    issue(OP_AND, 32'h0000_F0F0, 32'h0000_FF00, f1);
    issue(OP_OR,  32'h0000_F0F0, 32'h0000_0F0F, f2);
    idle_cycle();
    idle_cycle();
    chk("b2b_inready", 64'({f1, f2}), 64'(2'b11));
    diff = (cons_cyc.size() >= base + 2) ? cons_cyc[base + 1] - cons_cyc[base] : -1;
    chk("b2b_consecutive", 64'(diff), 64'd1);

    OutReady = 1'b0;
    issue(OP_XOR, 32'h1234_5678, 32'h0F0F_0F0F, f1);
    snap = 32'h1234_5678 ^ 32'h0F0F_0F0F;
    idle_cycle();
    base = n_cons;
    for (int unsigned i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      InValid = 1'b1; Operation = 4'($urandom_range(0, 15)); DataIn1 = $urandom; DataIn2 = $urandom;
      @(negedge clk);
      chk("bp_inready", 64'(InReady), 64'd0);
      chk("bp_stable", 64'({OutValid, Result}), {31'b0, 1'b1, snap});
    end
    @(posedge clk); #1;
    InValid = 1'b0; OutReady = 1'b1;
    @(posedge clk); #1;
    OutReady = 1'b0;
    @(negedge clk);
    chk("bp_one_consume", 64'(n_cons - base), 64'd1);
    chk("bp_idle_after", 64'(OutValid), 64'd0);

`ifdef ALU_STREAM_MUL_EN
    OutReady = 1'b1;
    issue(OP_MUL, 32'hFFFF_FFFF, 32'h0000_0002, f1);
    n = 0;
    seen = 1'b0;
    while (!seen && n < 100) begin
      @(posedge clk); n++; #1;
      InValid = 1'b0;
      @(negedge clk);
      seen = OutValid;
    end
    chk("mul_latency", 64'(n), 64'(WIDTH + 1));
    chk("mul_result", {ResultHi, Result}, 64'h0000_0001_FFFF_FFFE);

    issue(OP_MUL, 32'hFFFF_FFFF, 32'h0000_0002, f1);
    idle_cycle();
    repeat (9) @(posedge clk);
    #1;
    rst_n = 1'b0;
    q.delete();
    @(negedge clk);
    chk("abort_flags", 64'({OutValid, InReady}), 64'(2'b01));
    @(posedge clk); #1;
    rst_n = 1'b1;
    seen = 1'b0;
    repeat (WIDTH + 8) begin
      @(negedge clk);
      if (OutValid) seen = 1'b1;
    end
    chk("abort_no_result", 64'(seen), 64'd0);
    chk("abort_inready", 64'(InReady), 64'd1);
`endif

    rand_ready = 1'b1;
    for (int unsigned i = 0; i < 300; i++) begin
      if ($urandom % 5 == 0) idle_cycle();
      else issue(4'($urandom_range(0, 15)), pick(), pick(), f1);
    end
    idle_cycle();
    rand_ready = 1'b0;
    @(posedge clk); #1;
    OutReady = 1'b1;
    n = 0;
    while (q.size() != 0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    @(negedge clk);
    chk("drain_empty", 64'(q.size()), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
